// File: rtl/fetch_line_buffer.sv
// fetch_line_buffer: single-line instruction fetch buffer in front of the LLC.
// Holds one cache line (data, tag and valid bit). Fetches that hit the line are
// answered one cycle after acceptance. Misses issue a line read to the LLC, refill
// the buffer and then answer. Misaligned fetches (addr[1:0] != 0) are answered
// with resp_err and leave the buffer and the counters untouched.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   req_addr/valid      core fetch byte address and request valid
//   req_ready           high only when idle (request accepted this cycle)
//   resp_data/err/valid instruction word, misalignment flag, response valid
//   resp_ready          core accepts the response
//   flush               invalidate the line buffer (takes effect next cycle)
//   S_R_ADDR/_VALID     LLC line-aligned read request, held until data returns
//   S_R_DATA/_VALID     LLC line data and its valid strobe
//   hit_count           saturating count of buffer hits
//   miss_count          saturating count of buffer misses
module fetch_line_buffer #(
  parameter int unsigned BYTES_PER_LINE = 64,
  parameter int unsigned OFFSET_SIZE    = $clog2(BYTES_PER_LINE)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [63:0]                 req_addr,
  input  logic                        req_valid,
  output logic                        req_ready,
  output logic [31:0]                 resp_data,
  output logic                        resp_err,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  input  logic                        flush,
  output logic [63:0]                 S_R_ADDR,
  output logic                        S_R_ADDR_VALID,
  input  logic [BYTES_PER_LINE*8-1:0] S_R_DATA,
  input  logic                        S_R_DATA_VALID,
  output logic [31:0]                 hit_count,
  output logic [31:0]                 miss_count
);

  localparam int unsigned LineW  = BYTES_PER_LINE * 8;
  localparam int unsigned TagW   = 64 - OFFSET_SIZE;
  localparam int unsigned WidxW  = OFFSET_SIZE - 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MISS = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [TagW-1:0]  req_tag_q, req_tag_d;
  logic [WidxW-1:0] req_idx_q, req_idx_d;
  logic [LineW-1:0] line_q, line_d;
  logic [TagW-1:0]  tag_q, tag_d;
  logic             valid_q, valid_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic             resp_err_q, resp_err_d;
  logic [31:0]      hit_q, hit_d;
  logic [31:0]      miss_q, miss_d;

  logic [TagW-1:0]  req_tag;
  logic [WidxW-1:0] req_idx;
  logic             req_misaligned;
  logic             line_hit;

  // Little-endian word select: word k occupies bits 32k+31:32k.
  function automatic logic [31:0] word_sel(input logic [LineW-1:0] line,
                                           input logic [WidxW-1:0] idx);
    logic [LineW-1:0] sh;
    sh = line >> {idx, 5'b00000};
    return sh[31:0];
  endfunction

  assign req_tag        = req_addr[63:OFFSET_SIZE];
  assign req_idx        = req_addr[OFFSET_SIZE-1:2];
  assign req_misaligned = |req_addr[1:0];
  // A flush arriving with the request wins: treat the line as already invalid.
  assign line_hit       = valid_q && !flush && (tag_q == req_tag);

  always_comb begin
    state_d     = state_q;
    req_tag_d   = req_tag_q;
    req_idx_d   = req_idx_q;
    line_d      = line_q;
    tag_d       = tag_q;
    valid_d     = valid_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    hit_d       = hit_q;
    miss_d      = miss_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_tag_d = req_tag;
          req_idx_d = req_idx;
          if (req_misaligned) begin
            resp_err_d  = 1'b1;
            resp_data_d = '0;
            state_d     = RESP;
          end else if (line_hit) begin
            resp_err_d  = 1'b0;
            resp_data_d = word_sel(line_q, req_idx);
            hit_d       = (hit_q == 32'hFFFF_FFFF) ? hit_q : hit_q + 32'd1;
            state_d     = RESP;
          end else begin
            resp_err_d = 1'b0;
            miss_d     = (miss_q == 32'hFFFF_FFFF) ? miss_q : miss_q + 32'd1;
            state_d    = MISS;
          end
        end
      end
      MISS: begin
        if (S_R_DATA_VALID) begin
          line_d      = S_R_DATA;
          tag_d       = req_tag_q;
          valid_d     = 1'b1;
          resp_data_d = word_sel(S_R_DATA, req_idx_q);
          state_d     = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides a same-cycle refill: the word is still delivered, the line is not kept.
    if (flush) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      valid_q     <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      hit_q       <= '0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_tag_q   <= req_tag_d;
      req_idx_q   <= req_idx_d;
      valid_q     <= valid_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end

  // Line storage is only observed when valid_q is set, so it carries no reset.
  always_ff @(posedge clk) begin
    line_q <= line_d;
    tag_q  <= tag_d;
  end

  assign req_ready      = (state_q == IDLE);
  assign resp_valid     = (state_q == RESP);
  assign S_R_ADDR_VALID = (state_q == MISS);
  assign S_R_ADDR       = S_R_ADDR_VALID ? {req_tag_q, {OFFSET_SIZE{1'b0}}} : 64'd0;
  assign resp_data      = resp_data_q;
  assign resp_err       = resp_err_q;
  assign hit_count      = hit_q;
  assign miss_count     = miss_q;

endmodule

// File: tb/tb_fetch_line_buffer.sv
module tb_fetch_line_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  req_addr;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  resp_data;
  logic         resp_err;
  logic         resp_valid;
  logic         resp_ready;
  logic         flush;
  logic [63:0]  S_R_ADDR;
  logic         S_R_ADDR_VALID;
  logic [511:0] S_R_DATA;
  logic         S_R_DATA_VALID;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t        sb[$];
  logic [511:0] line_a;

  always #5 clk = ~clk;

  fetch_line_buffer dut (
    .clk           (clk),
    .reset         (reset),
    .req_addr      (req_addr),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .resp_data     (resp_data),
    .resp_err      (resp_err),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .flush         (flush),
    .S_R_ADDR      (S_R_ADDR),
    .S_R_ADDR_VALID(S_R_ADDR_VALID),
    .S_R_DATA      (S_R_DATA),
    .S_R_DATA_VALID(S_R_DATA_VALID),
    .hit_count     (hit_count),
    .miss_count    (miss_count)
  );

  function automatic logic [511:0] mk_line(input logic [31:0] seed);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = seed + 32'(i);
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [63:0] addr, input logic fl,
                       input logic [31:0] edata, input logic eerr);
    resp_t e;
    check("req_ready_before_issue", 64'(req_ready), 64'd1);
    e.data = edata;
    e.err  = eerr;
    sb.push_back(e);
    req_addr  = addr;
    req_valid = 1'b1;
    flush     = fl;
    step();
    req_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic serve_llc(input logic [511:0] line, input int delay, input logic fl,
                           input logic [63:0] eaddr);
    for (int i = 0; i < delay; i++) begin
      check("llc_addr_valid_held", 64'(S_R_ADDR_VALID), 64'd1);
      check("llc_addr_held", S_R_ADDR, eaddr);
      step();
    end
    S_R_DATA       = line;
    S_R_DATA_VALID = 1'b1;
    flush          = fl;
    step();
    S_R_DATA_VALID = 1'b0;
    flush          = 1'b0;
    S_R_DATA       = {16{32'hBAD0_BAD0}};
  endtask

  task automatic get_resp(input int hold);
    int    n;
    resp_t e;
    n = 0;
    while (resp_valid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("resp_valid_timeout", 64'(resp_valid), 64'd1);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    check("resp_data", 64'(resp_data), 64'(e.data));
    check("resp_err", 64'(resp_err), 64'(e.err));
    check("req_ready_in_resp", 64'(req_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_resp_valid", 64'(resp_valid), 64'd1);
      check("hold_resp_data", 64'(resp_data), 64'(e.data));
      check("hold_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("resp_valid_drop", 64'(resp_valid), 64'd0);
    check("req_ready_after_resp", 64'(req_ready), 64'd1);
  endtask

  initial begin
    reset          = 1'b0;
    req_addr       = '0;
    req_valid      = 1'b0;
    resp_ready     = 1'b0;
    flush          = 1'b0;
    S_R_DATA       = '0;
    S_R_DATA_VALID = 1'b0;
    line_a         = mk_line(32'h5000_0000);
    line_a[63:32]  = 32'hDEAD_BEEF;

    // Reset state
    step();
    step();
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    check("rst_llc_valid", 64'(S_R_ADDR_VALID), 64'd0);
    check("rst_llc_addr", S_R_ADDR, 64'd0);
    check("rst_hit", 64'(hit_count), 64'd0);
    check("rst_miss", 64'(miss_count), 64'd0);
    reset = 1'b1;
    step();

    // Cold miss, LLC answers after 10 cycles
    issue(64'h1004, 1'b0, 32'hDEAD_BEEF, 1'b0);
    check("cold_miss_count", 64'(miss_count), 64'd1);
    check("cold_hit_count", 64'(hit_count), 64'd0);
    serve_llc(line_a, 10, 1'b0, 64'h1000);
    get_resp(0);

    // Hit, one-cycle latency, no LLC traffic
    issue(64'h1038, 1'b0, 32'h5000_000E, 1'b0);
    check("hit_latency", 64'(resp_valid), 64'd1);
    check("hit_no_llc", 64'(S_R_ADDR_VALID), 64'd0);
    check("hit_count_1", 64'(hit_count), 64'd1);
    check("hit_miss_count", 64'(miss_count), 64'd1);
    get_resp(0);

    // Misaligned fetch
    issue(64'h1002, 1'b0, 32'h0, 1'b1);
    check("misal_resp_valid", 64'(resp_valid), 64'd1);
    check("misal_no_llc", 64'(S_R_ADDR_VALID), 64'd0);
    check("misal_hit", 64'(hit_count), 64'd1);
    check("misal_miss", 64'(miss_count), 64'd1);
    get_resp(0);
    check("misal_no_llc_after", 64'(S_R_ADDR_VALID), 64'd0);

    // Backpressure for 5 cycles with stray LLC data that must be ignored
    issue(64'h1010, 1'b0, 32'h5000_0004, 1'b0);
    S_R_DATA       = {16{32'h1234_5678}};
    S_R_DATA_VALID = 1'b1;
    get_resp(5);
    S_R_DATA_VALID = 1'b0;
    check("bp_hit_count", 64'(hit_count), 64'd2);
    issue(64'h1014, 1'b0, 32'h5000_0005, 1'b0);
    check("stray_data_ignored_hit", 64'(hit_count), 64'd3);
    get_resp(0);

    // Reset in the middle of a fill
    issue(64'h3000, 1'b0, 32'h0, 1'b0);
    check("midfill_llc_valid", 64'(S_R_ADDR_VALID), 64'd1);
    check("midfill_miss", 64'(miss_count), 64'd2);
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    sb.delete();
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    check("midrst_llc_valid", 64'(S_R_ADDR_VALID), 64'd0);
    check("midrst_llc_addr", S_R_ADDR, 64'd0);
    check("midrst_hit", 64'(hit_count), 64'd0);
    check("midrst_miss", 64'(miss_count), 64'd0);
    check("midrst_resp_valid", 64'(resp_valid), 64'd0);

    // Flush coincident with refill: word delivered, line not retained
    issue(64'h1004, 1'b0, 32'hDEAD_BEEF, 1'b0);
    check("flushfill_miss_1", 64'(miss_count), 64'd1);
    serve_llc(line_a, 3, 1'b1, 64'h1000);
    get_resp(0);
    issue(64'h1004, 1'b0, 32'hDEAD_BEEF, 1'b0);
    check("refetch_is_miss", 64'(S_R_ADDR_VALID), 64'd1);
    check("refetch_miss_2", 64'(miss_count), 64'd2);
    check("refetch_hit_0", 64'(hit_count), 64'd0);
    serve_llc(line_a, 2, 1'b0, 64'h1000);
    get_resp(0);

    // Flush with a request in IDLE forces a miss
    issue(64'h1008, 1'b1, 32'h5000_0002, 1'b0);
    check("idleflush_miss_3", 64'(miss_count), 64'd3);
    check("idleflush_hit_0", 64'(hit_count), 64'd0);
    serve_llc(line_a, 1, 1'b0, 64'h1000);
    get_resp(0);
    issue(64'h100C, 1'b0, 32'h5000_0003, 1'b0);
    check("post_refill_hit_valid", 64'(resp_valid), 64'd1);
    check("post_refill_hit_1", 64'(hit_count), 64'd1);
    get_resp(0);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_line_buffer.md
FETCH_LINE_BUFFER -- requirements
Module: fetch_line_buffer

Interface
REQ-001 SHALL have parameter BYTES_PER_LINE, default 64, meaning bytes per cache line; line width is BYTES_PER_LINE*8 bits (512).
REQ-002 SHALL have parameter OFFSET_SIZE, default $clog2(BYTES_PER_LINE), meaning line-offset bits; TAG_SIZE = 64 - OFFSET_SIZE.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset (0 = reset, sampled on posedge clk).
REQ-005 SHALL have port req_addr, input, 64, the core fetch byte address.
REQ-006 SHALL have port req_valid, input, 1, the core fetch request valid.
REQ-007 SHALL have port req_ready, output, 1, high when the block accepts a request.
REQ-008 SHALL have port resp_data, output, 32, the fetched instruction word.
REQ-009 SHALL have port resp_err, output, 1, flagging a misaligned fetch; qualified by resp_valid.
REQ-010 SHALL have port resp_valid, output, 1, the response valid.
REQ-011 SHALL have port resp_ready, input, 1, the core accepting the response.
REQ-012 SHALL have port flush, input, 1, invalidating the line buffer.
REQ-013 SHALL have port S_R_ADDR, output, 64, the LLC read address (line-aligned).
REQ-014 SHALL have port S_R_ADDR_VALID, output, 1, the LLC read request.
REQ-015 SHALL have port S_R_DATA, input, 512, the LLC line data.
REQ-016 SHALL have port S_R_DATA_VALID, input, 1, LLC data valid.
REQ-017 SHALL have ports hit_count and miss_count, output, 32 each, fetch statistics.

Function
REQ-018 SHALL hold one line buffer: 512-bit data, TAG_SIZE-bit tag, valid bit.
REQ-019 SHALL implement FSM IDLE, MISS, RESP; req_ready=1 only in IDLE.
REQ-020 IDLE: on req_valid, latch req_addr; if req_addr[1:0]!=0 -> RESP with resp_err=1, no LLC request, no counter change.
REQ-021 IDLE, aligned, valid and tag==req_addr[63:OFFSET_SIZE] -> RESP (hit, 1-cycle latency to resp_valid); hit_count+1.
REQ-022 IDLE, aligned, miss -> MISS; miss_count+1.
REQ-023 MISS: S_R_ADDR = {latched tag, OFFSET_SIZE'b0}, S_R_ADDR_VALID=1, both held stable until S_R_DATA_VALID is sampled high; S_R_ADDR_VALID=0 in every other state.
REQ-024 MISS with S_R_DATA_VALID=1: capture S_R_DATA into buffer, set tag and valid -> RESP.
REQ-025 RESP: resp_valid=1; resp_data = line[32k+31:32k], k = latched addr[OFFSET_SIZE-1:2] (little-endian: byte b at bits 8b+7:8b); outputs stable until resp_ready.
REQ-026 RESP with resp_ready=1 -> IDLE; resp_valid drops next cycle; no new request is accepted in that same cycle.
REQ-027 flush=1 SHALL clear valid next cycle in any state; in-flight transaction still completes.
REQ-028 flush in same cycle as MISS line capture SHALL deliver the captured word to the core but leave valid=0.
REQ-029 flush in IDLE with req_valid SHALL evaluate hit/miss as miss (flush takes priority).
REQ-030 Counters SHALL saturate at 32'hFFFF_FFFF, never wrap.
REQ-031 S_R_DATA SHALL be ignored outside MISS.

Reset
REQ-032 reset=0 at posedge SHALL force state IDLE, valid=0, hit_count=0, miss_count=0, resp_valid=0, resp_err=0, resp_data=0, S_R_ADDR_VALID=0, S_R_ADDR=0; reset mid-MISS abandons the fill.
REQ-033 Buffer data and tag need no reset; outputs SHALL not depend on them while valid=0.

Verification
REQ-034 Cold fetch 0x1004 -> S_R_ADDR=0x1000 held; LLC returns line with word1=0xDEADBEEF after 10 cycles -> resp_data=0xDEADBEEF, resp_err=0, miss_count=1.
REQ-035 Then fetch 0x1038 -> resp_valid exactly 1 cycle after accept, no S_R_ADDR_VALID, resp_data=word14, hit_count=1.
REQ-036 Fetch 0x1002 -> resp_valid with resp_err=1, S_R_ADDR_VALID never asserted, counters unchanged.
REQ-037 flush pulsed coincident with S_R_DATA_VALID, then refetch 0x1004 -> first response delivered, second access is a miss (miss_count=2).
REQ-038 resp_ready held low 5 cycles in RESP -> resp_valid/resp_data stable all 5 cycles, req_ready=0; reset=0 asserted during MISS -> next cycle IDLE, S_R_ADDR_VALID=0, counters 0.
